// File: rtl/xif_offload_ctrl_if.sv
// Core-side bundle for the XIF offload controller: decode handshake, issue,
// commit, result and register-file writeback channels.
interface xif_offload_ctrl_if #(
   parameter int XLEN            = 32,
   parameter int X_ID_WIDTH      = 4,
   parameter int X_NUM_RS        = 3,
   parameter int MAX_OUTSTANDING = 4
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   logic                       instr_valid;
   logic [31:0]                instr;
   logic [X_NUM_RS*XLEN-1:0]   rs_i;
   logic [X_NUM_RS-1:0]        rs_valid_i;
   logic                       kill_i;
   logic                       instr_ready;
   logic                       issue_valid;
   logic                       issue_ready;
   logic [31:0]                issue_instr;
   logic [X_ID_WIDTH-1:0]      issue_id;
   logic [X_NUM_RS*XLEN-1:0]   issue_rs;
   logic [X_NUM_RS-1:0]        issue_rs_valid;
   logic                       issue_accept;
   logic                       commit_valid;
   logic [X_ID_WIDTH-1:0]      commit_id;
   logic                       commit_kill;
   logic                       result_valid;
   logic                       result_ready;
   logic [X_ID_WIDTH-1:0]      result_id;
   logic [XLEN-1:0]            result_data;
   logic [4:0]                 result_rd;
   logic                       result_we;
   logic                       wb_valid;
   logic [4:0]                 wb_rd;
   logic [XLEN-1:0]            wb_data;
   logic                       illegal_instr;
   logic [OW-1:0]              outstanding;
   logic                       proto_err;

   // controller side
   modport master (
      input  instr_valid, instr, rs_i, rs_valid_i, kill_i,
      input  issue_ready, issue_accept,
      input  result_valid, result_id, result_data, result_rd, result_we,
      output instr_ready, issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
      output commit_valid, commit_id, commit_kill, result_ready,
      output wb_valid, wb_rd, wb_data, illegal_instr, outstanding, proto_err
   );

   // core + coprocessor side
   modport slave (
      output instr_valid, instr, rs_i, rs_valid_i, kill_i,
      output issue_ready, issue_accept,
      output result_valid, result_id, result_data, result_rd, result_we,
      input  instr_ready, issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
      input  commit_valid, commit_id, commit_kill, result_ready,
      input  wb_valid, wb_rd, wb_data, illegal_instr, outstanding, proto_err
   );
endinterface

// File: rtl/xif_offload_ctrl.sv
// Core-side CORE-V-XIF initiator: issues one instruction at a time, emits
// commit/kill, tracks outstanding work and forwards results to the regfile.
module xif_offload_ctrl #(
   parameter int XLEN            = 32,
   parameter int X_ID_WIDTH      = 4,
   parameter int X_NUM_RS        = 3,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic ck,
   input logic rst,
   xif_offload_ctrl_if.master bus
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMMIT} state_t;

   state_t                   r_state, w_next;
   logic [31:0]              r_instr;
   logic [X_NUM_RS*XLEN-1:0] r_rs;
   logic [X_NUM_RS-1:0]      r_rsv;
   logic [X_ID_WIDTH-1:0]    r_id, r_id_cnt;
   logic                     r_kill, r_illegal, r_res_rdy, r_wb_valid, r_perr;
   logic [4:0]               r_wb_rd;
   logic [XLEN-1:0]          r_wb_data;
   logic [OW-1:0]            r_out;

   logic w_instr_rdy, w_instr_hs, w_issue_hs, w_res_hs, w_inc, w_dec;
   logic w_issue_valid, w_commit_valid;

   assign w_instr_rdy = (r_state == S_IDLE) && (r_out < OW'(MAX_OUTSTANDING)) && !rst;
   assign w_instr_hs  = bus.instr_valid && w_instr_rdy;
   assign w_issue_hs  = (r_state == S_ISSUE) && bus.issue_ready;
   assign w_res_hs    = bus.result_valid && r_res_rdy;
   assign w_inc       = w_issue_hs && bus.issue_accept && !bus.kill_i;
   // a result with nothing outstanding is a protocol error, never an underflow
   assign w_dec       = w_res_hs && (r_out != '0);

   always_comb begin
      w_next         = r_state;
      w_issue_valid  = 1'b0;
      w_commit_valid = 1'b0;
      case (r_state)
         S_IDLE:   if (w_instr_hs) w_next = S_ISSUE;
         S_ISSUE: begin
            w_issue_valid = 1'b1;
            if (w_issue_hs) w_next = bus.issue_accept ? S_COMMIT : S_IDLE;
         end
         S_COMMIT: begin
            w_commit_valid = 1'b1;
            w_next         = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_instr   <= '0;
         r_rs      <= '0;
         r_rsv     <= '0;
         r_id      <= '0;
         r_id_cnt  <= '0;
         r_kill    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_issue_hs && !bus.issue_accept;
         if (w_instr_hs) begin
            r_instr <= bus.instr;
            r_rs    <= bus.rs_i;
            r_rsv   <= bus.rs_valid_i;
            r_id    <= r_id_cnt;
         end
         if (w_issue_hs) begin
            r_id_cnt <= r_id_cnt + 1'b1;
            r_kill   <= bus.kill_i;
         end
      end
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_res_rdy  <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_out      <= '0;
         r_perr     <= 1'b0;
      end else begin
         r_res_rdy  <= 1'b1;
         r_wb_valid <= w_res_hs && bus.result_we;
         if (w_res_hs) begin
            r_wb_rd   <= bus.result_rd;
            r_wb_data <= bus.result_data;
            if (r_out == '0) r_perr <= 1'b1;
         end
         case ({w_inc, w_dec})
            2'b10:   r_out <= r_out + OW'(1);
            2'b01:   r_out <= r_out - OW'(1);
            default: r_out <= r_out;
         endcase
      end
   end

   assign bus.instr_ready    = w_instr_rdy;
   assign bus.issue_valid    = w_issue_valid;
   assign bus.issue_instr    = r_instr;
   assign bus.issue_id       = r_id;
   assign bus.issue_rs       = r_rs;
   assign bus.issue_rs_valid = r_rsv;
   assign bus.commit_valid   = w_commit_valid;
   assign bus.commit_id      = r_id;
   assign bus.commit_kill    = w_commit_valid && r_kill;
   assign bus.result_ready   = r_res_rdy;
   assign bus.wb_valid       = r_wb_valid;
   assign bus.wb_rd          = r_wb_rd;
   assign bus.wb_data        = r_wb_data;
   assign bus.illegal_instr  = r_illegal;
   assign bus.outstanding    = r_out;
   assign bus.proto_err      = r_perr;
endmodule

// File: tb/tb_xif_offload_ctrl.sv
// Randomized self-checking bench for xif_offload_ctrl with a counter-level reference model.
module tb_xif_offload_ctrl;
   localparam int XLEN = 32, XIDW = 4, NRS = 3, MAXO = 4;

   logic ck = 1'b0;
   logic rst = 1'b1;
   always #5 ck = ~ck;

   xif_offload_ctrl_if #(.XLEN(XLEN), .X_ID_WIDTH(XIDW), .X_NUM_RS(NRS), .MAX_OUTSTANDING(MAXO)) bus ();
   xif_offload_ctrl #(.XLEN(XLEN), .X_ID_WIDTH(XIDW), .X_NUM_RS(NRS), .MAX_OUTSTANDING(MAXO))
      dut (.ck(ck), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   // reference model: next id, accepted-and-live count, sticky error
   int m_id   = 0;
   int m_out  = 0;
   bit m_perr = 1'b0;

   task automatic step;
      @(posedge ck);
      #1;
   endtask

   task automatic do_issue(input logic [31:0] ins, input logic [NRS*XLEN-1:0] rs,
                           input logic [NRS-1:0] rsv, input bit acc, input bit kill,
                           input int stall, input bit with_res);
      int n, exp_id, pre;
      n = 0;
      while (bus.instr_ready !== 1'b1 && n < 20) begin step; n++; end
      checks++;
      if (bus.instr_ready !== 1'b1) begin
         $display("FAIL instr_ready_wait got %b want 1", bus.instr_ready); errors++;
      end
      bus.instr_valid = 1'b1; bus.instr = ins; bus.rs_i = rs; bus.rs_valid_i = rsv;
      step;
      bus.instr_valid = 1'b0; bus.instr = $urandom;
      bus.rs_i = {$urandom, $urandom, $urandom}; bus.rs_valid_i = 3'($urandom);
      exp_id = m_id;
      for (int i = 0; i <= stall; i++) begin
         checks++;
         if (bus.issue_valid !== 1'b1 || bus.issue_instr !== ins || bus.issue_rs !== rs ||
             bus.issue_rs_valid !== rsv || bus.issue_id !== 4'(exp_id)) begin
            $display("FAIL issue_hold cyc %0d got v=%b i=%h id=%0d rsv=%b want v=1 i=%h id=%0d rsv=%b",
                     i, bus.issue_valid, bus.issue_instr, bus.issue_id, bus.issue_rs_valid,
                     ins, exp_id, rsv);
            errors++;
         end
         if (i < stall) step;
      end
      bus.issue_ready = 1'b1; bus.issue_accept = acc; bus.kill_i = kill;
      if (with_res) begin
         bus.result_valid = 1'b1; bus.result_id = 4'(exp_id); bus.result_we = 1'b0;
      end
      step;
      bus.issue_ready = 1'b0; bus.issue_accept = 1'b0; bus.kill_i = 1'b0; bus.result_valid = 1'b0;
      pre   = m_out;
      m_id  = (m_id + 1) % 16;
      m_out = pre + ((acc && !kill) ? 1 : 0) - ((with_res && pre > 0) ? 1 : 0);
      if (with_res && pre == 0) m_perr = 1'b1;
      checks++;
      if (acc) begin
         if (bus.commit_valid !== 1'b1 || bus.commit_id !== 4'(exp_id) ||
             bus.commit_kill !== kill || bus.illegal_instr !== 1'b0) begin
            $display("FAIL commit got v=%b id=%0d k=%b ill=%b want v=1 id=%0d k=%b ill=0",
                     bus.commit_valid, bus.commit_id, bus.commit_kill, bus.illegal_instr, exp_id, kill);
            errors++;
         end
      end else begin
         if (bus.illegal_instr !== 1'b1 || bus.commit_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin
            $display("FAIL reject got ill=%b cv=%b rdy=%b want ill=1 cv=0 rdy=1",
                     bus.illegal_instr, bus.commit_valid, bus.instr_ready);
            errors++;
         end
      end
      checks++;
      if (bus.outstanding !== 3'(m_out) || bus.issue_valid !== 1'b0) begin
         $display("FAIL outstanding_after_issue got %0d iv=%b want %0d iv=0",
                  bus.outstanding, bus.issue_valid, m_out);
         errors++;
      end
      step;
      checks++;
      if (bus.commit_valid !== 1'b0 || bus.illegal_instr !== 1'b0) begin
         $display("FAIL pulse_width got cv=%b ill=%b want 0 0", bus.commit_valid, bus.illegal_instr);
         errors++;
      end
   endtask

   task automatic do_result(input logic [3:0] id, input logic [31:0] data,
                            input logic [4:0] rd, input bit we);
      bus.result_valid = 1'b1; bus.result_id = id; bus.result_data = data;
      bus.result_rd = rd; bus.result_we = we;
      step;
      bus.result_valid = 1'b0; bus.result_data = $urandom; bus.result_rd = 5'($urandom);
      if (m_out == 0) m_perr = 1'b1;
      else            m_out--;
      checks++;
      if (bus.wb_valid !== we || (we && (bus.wb_rd !== rd || bus.wb_data !== data)) ||
          bus.outstanding !== 3'(m_out) || bus.proto_err !== m_perr) begin
         $display("FAIL result got wb=%b rd=%0d d=%h out=%0d pe=%b want wb=%b rd=%0d d=%h out=%0d pe=%b",
                  bus.wb_valid, bus.wb_rd, bus.wb_data, bus.outstanding, bus.proto_err,
                  we, rd, data, m_out, m_perr);
         errors++;
      end
      step;
      checks++;
      if (bus.wb_valid !== 1'b0) begin
         $display("FAIL wb_pulse got %b want 0", bus.wb_valid); errors++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (bus.issue_valid !== 1'b0 || bus.commit_valid !== 1'b0 || bus.commit_kill !== 1'b0 ||
          bus.wb_valid !== 1'b0 || bus.illegal_instr !== 1'b0 || bus.proto_err !== 1'b0 ||
          bus.result_ready !== 1'b0 || bus.instr_ready !== 1'b0 || bus.outstanding !== 3'd0 ||
          bus.issue_instr !== 32'd0 || bus.issue_id !== 4'd0 || bus.issue_rs !== '0 ||
          bus.issue_rs_valid !== 3'd0 || bus.commit_id !== 4'd0 || bus.wb_rd !== 5'd0 ||
          bus.wb_data !== 32'd0) begin
         $display("FAIL %s got iv=%b cv=%b wb=%b ill=%b pe=%b rr=%b ir=%b out=%0d instr=%h id=%0d want all zero",
                  tag, bus.issue_valid, bus.commit_valid, bus.wb_valid, bus.illegal_instr,
                  bus.proto_err, bus.result_ready, bus.instr_ready, bus.outstanding,
                  bus.issue_instr, bus.issue_id);
         errors++;
      end
   endtask

   task automatic rand_issue(input bit acc, input bit kill);
      do_issue($urandom, {$urandom, $urandom, $urandom}, 3'($urandom), acc, kill,
               $urandom_range(0, 3), 1'b0);
   endtask

   task automatic test_reset;
      #1;
      check_reset_outputs("reset_state");
      @(negedge ck); rst = 1'b0;
      step;
      checks++;
      if (bus.result_ready !== 1'b1 || bus.instr_ready !== 1'b1) begin
         $display("FAIL ready_after_reset got rr=%b ir=%b want 1 1", bus.result_ready, bus.instr_ready);
         errors++;
      end
   endtask

   task automatic test_single;
      do_issue(32'h00A5_8553, {32'h0, 32'h0, 32'h3F80_0000}, 3'b001, 1'b1, 1'b0, 3, 1'b0);
      do_result(4'd0, 32'h4000_0000, 5'd10, 1'b1);
   endtask

   task automatic test_reject;
      rand_issue(1'b0, 1'b0);
      checks++;
      if (bus.outstanding !== 3'd0) begin
         $display("FAIL reject_outstanding got %0d want 0", bus.outstanding); errors++;
      end
      rand_issue(1'b1, 1'b0);
      do_result(4'd2, $urandom, 5'($urandom), 1'b0);
   endtask

   task automatic test_kill;
      rand_issue(1'b1, 1'b1);
   endtask

   task automatic test_backpressure;
      for (int i = 0; i < MAXO; i++) rand_issue(1'b1, 1'b0);
      step;
      checks++;
      if (bus.outstanding !== 3'd4 || bus.instr_ready !== 1'b0) begin
         $display("FAIL full got out=%0d rdy=%b want 4 0", bus.outstanding, bus.instr_ready); errors++;
      end
      do_result(4'($urandom), $urandom, 5'($urandom), 1'b1);
      checks++;
      if (bus.outstanding !== 3'd3 || bus.instr_ready !== 1'b1) begin
         $display("FAIL drain_one got out=%0d rdy=%b want 3 1", bus.outstanding, bus.instr_ready); errors++;
      end
      for (int i = 0; i < 3; i++) do_result(4'($urandom), $urandom, 5'($urandom), 1'($urandom));
   endtask

   task automatic test_simul;
      rand_issue(1'b1, 1'b0);
      do_issue($urandom, {$urandom, $urandom, $urandom}, 3'($urandom), 1'b1, 1'b0, 1, 1'b1);
      checks++;
      if (bus.outstanding !== 3'd1) begin
         $display("FAIL simul_outstanding got %0d want 1", bus.outstanding); errors++;
      end
      do_result(4'($urandom), $urandom, 5'($urandom), 1'b1);
   endtask

   task automatic test_wrap;
      bit acc, kill;
      for (int i = 0; i < 17; i++) begin
         acc  = 1'($urandom_range(0, 3) != 0);
         kill = 1'($urandom_range(0, 3) == 0);
         rand_issue(acc, kill);
         if (acc && !kill) do_result(4'($urandom), $urandom, 5'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_proto;
      do_result(4'($urandom), $urandom, 5'($urandom), 1'b1);
      step; step;
      checks++;
      if (bus.proto_err !== 1'b1 || bus.outstanding !== 3'd0) begin
         $display("FAIL proto_sticky got pe=%b out=%0d want 1 0", bus.proto_err, bus.outstanding); errors++;
      end
      rand_issue(1'b1, 1'b0);
   endtask

   task automatic test_rst_mid;
      while (bus.instr_ready !== 1'b1) step;
      bus.instr_valid = 1'b1; bus.instr = $urandom; bus.rs_i = {$urandom, $urandom, $urandom};
      bus.rs_valid_i = 3'b111;
      step;
      bus.instr_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("reset_mid_issue");
      m_id = 0; m_out = 0; m_perr = 1'b0;
      @(negedge ck); rst = 1'b0;
      step;
      rand_issue(1'b1, 1'b0);
      do_result(4'd0, $urandom, 5'($urandom), 1'b1);
   endtask

   initial begin
      bus.instr_valid = 1'b0; bus.instr = '0; bus.rs_i = '0; bus.rs_valid_i = '0; bus.kill_i = 1'b0;
      bus.issue_ready = 1'b0; bus.issue_accept = 1'b0;
      bus.result_valid = 1'b0; bus.result_id = '0; bus.result_data = '0;
      bus.result_rd = '0; bus.result_we = 1'b0;
      test_reset;
      test_single;
      test_reject;
      test_kill;
      test_backpressure;
      test_simul;
      test_wrap;
      test_proto;
      test_rst_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
